pc_sequencer: RTL and testbench

Controller that drives the 3-bit selector and write enable of the PC-input multiplexer in the multicycle CPU. It sequences every PC update: the PC+4 write at fetch, branch/jump/return-from-exception resolution after decode, and the exception entry sequence (EPC save, vector read, PC load). It sits between the main control FSM and the PC register / PC-source mux.

---
 rtl/pc_sequencer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Drives the PC-input mux selector and the PC / EPC load enables of the
// multicycle CPU. Every PC update passes through here: the PC+4 write at
// fetch, branch/jump/RTE resolution after decode, and the exception entry
// sequence (save EPC, read the vector byte from memory, load the PC from it).
//
// Parameters
//   MEM_LAT   cycles from vec_rd assertion until mem_data holds the vector byte
//   VEC_BASE  address of the first exception vector byte
//             (opcode +0, overflow +1, div-by-zero +2)
//
// Ports
//   clk            system clock
//   reset_n        synchronous active-low reset, sampled on rising clk
//   fetch_start    1-cycle pulse: main control begins a new fetch
//   resolve_valid  1-cycle pulse: instr_class / branch_cond / flags valid
//   instr_class    0=SEQ 1=BRANCH 2=JUMP 3=RTE (4..7 behave as SEQ)
//   branch_cond    0=BEQ 1=BNE 2=BLE 3=BGT
//   alu_zero       ALU zero flag
//   alu_gt         ALU greater-than flag
//   exc_req        bit0 invalid opcode, bit1 overflow, bit2 div-by-zero
//   mem_data       byte returned from memory for the vector read
//   pc_src         mux select: 0=PC+4 1=ALUOut 2=jump 3=EPC 4=vector
//   pc_write       PC register load enable
//   epc_write      EPC register load enable
//   vec_rd         memory read request for the vector byte
//   vec_addr       address of the vector byte being read
//   vec_byte       mem_data zero-extended and held (mux input 4)
//   exc_cause      0=none 1=opcode 2=overflow 3=div0, cleared at next fetch
//   busy           high in every state except IDLE
//   done           1-cycle pulse when the PC update is complete
//   fsm_state      current FSM state encoding, for observation only
//
// Handshake: fetch_start, resolve_valid and exc_req carry no ready signal.
// They are single-cycle strobes that the sequencer samples on a rising edge
// only in the state that accepts them (fetch_start in IDLE, exc_req and
// resolve_valid in WAIT); in any other state they are dropped. done is the
// completion strobe back to main control.
//
// Every output is a register. The combinational process computes the state
// that will be entered on the next edge together with the output values that
// belong to that state, so outputs always line up with the state they
// describe and never glitch between edges.
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int          MEM_LAT  = 2,
    parameter logic [31:0] VEC_BASE = 32'd253
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_start,
    input  logic        resolve_valid,
    input  logic [2:0]  instr_class,
    input  logic [1:0]  branch_cond,
    input  logic        alu_zero,
    input  logic        alu_gt,
    input  logic [2:0]  exc_req,
    input  logic [7:0]  mem_data,
    output logic [2:0]  pc_src,
    output logic        pc_write,
    output logic        epc_write,
    output logic        vec_rd,
    output logic [31:0] vec_addr,
    output logic [31:0] vec_byte,
    output logic [1:0]  exc_cause,
    output logic        busy,
    output logic        done,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT     = 3'd2,
        RESOLVE  = 3'd3,
        EXC_SAVE = 3'd4,
        EXC_READ = 3'd5,
        EXC_LOAD = 3'd6
    } state_t;

    // Mux select encodings
    localparam logic [2:0] SRC_PC4 = 3'd0;
    localparam logic [2:0] SRC_ALU = 3'd1;
    localparam logic [2:0] SRC_JMP = 3'd2;
    localparam logic [2:0] SRC_EPC = 3'd3;
    localparam logic [2:0] SRC_VEC = 3'd4;

    // Instruction classes
    localparam logic [2:0] CLS_BRANCH = 3'd1;
    localparam logic [2:0] CLS_JUMP   = 3'd2;
    localparam logic [2:0] CLS_RTE    = 3'd3;

    // Branch conditions
    localparam logic [1:0] COND_BEQ = 2'd0;
    localparam logic [1:0] COND_BNE = 2'd1;
    localparam logic [1:0] COND_BLE = 2'd2;
    localparam logic [1:0] COND_BGT = 2'd3;

    // Read-latency counter: counts the vec_rd cycles already spent in
    // EXC_READ. The last read cycle is the one where cnt == CNT_LAST.
    localparam int                CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    logic [2:0]         pc_src_nxt;
    logic               pc_write_nxt;
    logic               epc_write_nxt;
    logic               vec_rd_nxt;
    logic [31:0]        vec_addr_nxt;
    logic [31:0]        vec_byte_nxt;
    logic [1:0]         exc_cause_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    logic [1:0]         req_cause;
    logic               branch_taken;

    // Highest-priority pending exception: opcode > overflow > div0.
    always_comb begin
        req_cause = 2'd0;
        if (exc_req[0]) begin
            req_cause = 2'd1;
        end else if (exc_req[1]) begin
            req_cause = 2'd2;
        end else if (exc_req[2]) begin
            req_cause = 2'd3;
        end
    end

    // Branch outcome from the compare flags presented with resolve_valid.
    always_comb begin
        branch_taken = 1'b0;
        case (branch_cond)
            COND_BEQ: branch_taken = alu_zero;
            COND_BNE: branch_taken = !alu_zero;
            COND_BLE: branch_taken = !alu_gt;
            COND_BGT: branch_taken = alu_gt;
            default:  branch_taken = 1'b0;
        endcase
    end

    // Next state and the output values belonging to that state.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pc_src_nxt    = SRC_PC4;
        pc_write_nxt  = 1'b0;
        epc_write_nxt = 1'b0;
        vec_rd_nxt    = 1'b0;
        done_nxt      = 1'b0;
        vec_addr_nxt  = vec_addr;
        vec_byte_nxt  = vec_byte;
        exc_cause_nxt = exc_cause;

        case (state)
            IDLE: begin
                if (fetch_start) begin
                    state_nxt     = FETCH;
                    pc_src_nxt    = SRC_PC4;
                    pc_write_nxt  = 1'b1;
                    exc_cause_nxt = 2'd0;
                end
            end

            FETCH: begin
                state_nxt = WAIT;
            end

            WAIT: begin
                if (|exc_req) begin
                    // Exception wins over a simultaneous resolve_valid.
                    state_nxt     = EXC_SAVE;
                    epc_write_nxt = 1'b1;
                    exc_cause_nxt = req_cause;
                    vec_addr_nxt  = VEC_BASE + 32'(req_cause) - 32'd1;
                end else if (resolve_valid) begin
                    // The decode result is consumed on this edge: the
                    // registered pc_src / pc_write hold the resolution for
                    // the RESOLVE cycle.
                    state_nxt = RESOLVE;
                    done_nxt  = 1'b1;
                    case (instr_class)
                        CLS_BRANCH: begin
                            if (branch_taken) begin
                                pc_src_nxt   = SRC_ALU;
                                pc_write_nxt = 1'b1;
                            end
                        end
                        CLS_JUMP: begin
                            pc_src_nxt   = SRC_JMP;
                            pc_write_nxt = 1'b1;
                        end
                        CLS_RTE: begin
                            pc_src_nxt   = SRC_EPC;
                            pc_write_nxt = 1'b1;
                        end
                        default: begin
                            // SEQ and unused classes: PC+4 was already
                            // written during FETCH, nothing more to load.
                            pc_write_nxt = 1'b0;
                        end
                    endcase
                end
            end

            RESOLVE: begin
                state_nxt = IDLE;
            end

            EXC_SAVE: begin
                state_nxt  = EXC_READ;
                cnt_nxt    = '0;
                vec_rd_nxt = 1'b1;
            end

            EXC_READ: begin
                if (cnt == CNT_LAST) begin
                    // Last read cycle: memory now presents the vector byte.
                    state_nxt    = EXC_LOAD;
                    vec_byte_nxt = {24'd0, mem_data};
                    pc_src_nxt   = SRC_VEC;
                    pc_write_nxt = 1'b1;
                    done_nxt     = 1'b1;
                end else begin
                    cnt_nxt    = cnt + 1'b1;
                    vec_rd_nxt = 1'b1;
                end
            end

            EXC_LOAD: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pc_src    <= SRC_PC4;
            pc_write  <= 1'b0;
            epc_write <= 1'b0;
            vec_rd    <= 1'b0;
            vec_addr  <= 32'd0;
            vec_byte  <= 32'd0;
            exc_cause <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pc_src    <= pc_src_nxt;
            pc_write  <= pc_write_nxt;
            epc_write <= epc_write_nxt;
            vec_rd    <= vec_rd_nxt;
            vec_addr  <= vec_addr_nxt;
            vec_byte  <= vec_byte_nxt;
            exc_cause <= exc_cause_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. Driver tasks issue fetch / resolve /
// exception stimulus and push the expected active cycles (cycle number plus
// every output) into exp_q. A negedge monitor compares each cycle in which
// the DUT shows pc_write, epc_write, vec_rd or done against the queue head,
// so extra, missing, or mistimed updates all show up. Quiet-state properties
// (reset values, ignored inputs) are checked directly by the driver.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int          MEM_LAT  = 2;
    localparam logic [31:0] VEC_BASE = 32'd253;
    localparam int          W        = 106;

    localparam logic [2:0]  ST_IDLE = 3'd0;
    localparam logic [2:0]  ST_WAIT = 3'd2;

    logic        clk;
    logic        reset_n;
    logic        fetch_start;
    logic        resolve_valid;
    logic [2:0]  instr_class;
    logic [1:0]  branch_cond;
    logic        alu_zero;
    logic        alu_gt;
    logic [2:0]  exc_req;
    logic [7:0]  mem_data;
    logic [2:0]  pc_src;
    logic        pc_write;
    logic        epc_write;
    logic        vec_rd;
    logic [31:0] vec_addr;
    logic [31:0] vec_byte;
    logic [1:0]  exc_cause;
    logic        busy;
    logic        done;
    logic [2:0]  fsm_state;

    pc_sequencer #(
        .MEM_LAT  (MEM_LAT),
        .VEC_BASE (VEC_BASE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_start   (fetch_start),
        .resolve_valid (resolve_valid),
        .instr_class   (instr_class),
        .branch_cond   (branch_cond),
        .alu_zero      (alu_zero),
        .alu_gt        (alu_gt),
        .exc_req       (exc_req),
        .mem_data      (mem_data),
        .pc_src        (pc_src),
        .pc_write      (pc_write),
        .epc_write     (epc_write),
        .vec_rd        (vec_rd),
        .vec_addr      (vec_addr),
        .vec_byte      (vec_byte),
        .exc_cause     (exc_cause),
        .busy          (busy),
        .done          (done),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [1:0]   exp_cause;
    logic [31:0]  exp_addr;
    logic [31:0]  exp_byte;
    logic [W-1:0] mon_act;
    logic [W-1:0] mon_exp;

    function automatic logic [W-1:0] mk(input logic [31:0] c, input logic [2:0] src,
                                        input logic pw, input logic epc, input logic rd,
                                        input logic dn, input logic bz, input logic [1:0] cause,
                                        input logic [31:0] addr, input logic [31:0] byt);
        return {c, src, pw, epc, rd, dn, bz, cause, addr, byt};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (pc_write === 1'b1 || epc_write === 1'b1 || vec_rd === 1'b1 || done === 1'b1) begin
            mon_act = {cyc, pc_src, pc_write, epc_write, vec_rd, done, busy,
                       exc_cause, vec_addr, vec_byte};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_activity cyc=%0d got=%h expected=none", cyc, mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_err++;
                    $display("FAIL event cyc=%0d got=%h expected=%h", cyc, mon_act, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Called in IDLE; returns with the DUT in WAIT.
    task automatic do_fetch;
        fetch_start = 1'b1;
        exp_cause   = 2'd0;
        exp_q.push_back(mk(cyc + 32'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                           2'd0, exp_addr, exp_byte));
        step;
        fetch_start = 1'b0;
        step;
    endtask

    // Called in WAIT; returns with the DUT in IDLE.
    task automatic do_resolve(input logic [2:0] cls, input logic [1:0] cond,
                              input logic z, input logic gt,
                              input logic [2:0] src, input logic pw);
        instr_class   = cls;
        branch_cond   = cond;
        alu_zero      = z;
        alu_gt        = gt;
        resolve_valid = 1'b1;
        exp_q.push_back(mk(cyc + 32'd1, src, pw, 1'b0, 1'b0, 1'b1, 1'b1,
                           exp_cause, exp_addr, exp_byte));
        step;
        resolve_valid = 1'b0;
        instr_class   = 3'd0;
        alu_zero      = ~z;
        alu_gt        = ~gt;
        step;
    endtask

    // Called in WAIT; full exception entry, returns with the DUT in IDLE.
    task automatic do_exc(input logic [2:0] req, input logic rv, input logic [7:0] md,
                          input logic [1:0] cause, input logic [31:0] addr);
        logic [31:0] m;
        m             = cyc;
        exc_req       = req;
        resolve_valid = rv;
        instr_class   = 3'd2;
        exp_q.push_back(mk(m + 32'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                           cause, addr, exp_byte));
        for (int k = 0; k < MEM_LAT; k++) begin
            exp_q.push_back(mk(m + 32'd2 + 32'(k), 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                               cause, addr, exp_byte));
        end
        exp_q.push_back(mk(m + 32'd2 + 32'(MEM_LAT), 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                           cause, addr, {24'd0, md}));
        step;
        exc_req       = 3'd0;
        resolve_valid = 1'b0;
        instr_class   = 3'd0;
        mem_data      = 8'h33;
        repeat (MEM_LAT) step;
        // Only the last read cycle presents the real vector byte.
        mem_data = md;
        step;
        mem_data = 8'h44;
        step;
        exp_cause = cause;
        exp_addr  = addr;
        exp_byte  = {24'd0, md};
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n       = 1'b0;
        fetch_start   = 1'b0;
        resolve_valid = 1'b0;
        instr_class   = 3'd0;
        branch_cond   = 2'd0;
        alu_zero      = 1'b0;
        alu_gt        = 1'b0;
        exc_req       = 3'd0;
        mem_data      = 8'h00;
        exp_cause     = 2'd0;
        exp_addr      = 32'd0;
        exp_byte      = 32'd0;

        repeat (3) step;
        check("reset_ctrl", 64'({pc_src, pc_write, epc_write, vec_rd, busy, done,
                                 exc_cause, fsm_state}), 64'd0);
        check("reset_vec", {vec_addr, vec_byte}, 64'd0);
        reset_n = 1'b1;
        step;

        // SEQ
        do_fetch;
        check("wait_busy", 64'({fsm_state, busy}), 64'({ST_WAIT, 1'b1}));
        do_resolve(3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Branch conditions: taken -> src 1 / write 1, not taken -> write 0
        do_fetch; do_resolve(3'd1, 2'd0, 1'b1, 1'b0, 3'd1, 1'b1);  // BEQ z=1
        do_fetch; do_resolve(3'd1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);  // BEQ z=0
        do_fetch; do_resolve(3'd1, 2'd1, 1'b0, 1'b0, 3'd1, 1'b1);  // BNE z=0
        do_fetch; do_resolve(3'd1, 2'd1, 1'b1, 1'b0, 3'd0, 1'b0);  // BNE z=1
        do_fetch; do_resolve(3'd1, 2'd2, 1'b0, 1'b0, 3'd1, 1'b1);  // BLE gt=0
        do_fetch; do_resolve(3'd1, 2'd2, 1'b0, 1'b1, 3'd0, 1'b0);  // BLE gt=1
        do_fetch; do_resolve(3'd1, 2'd3, 1'b0, 1'b1, 3'd1, 1'b1);  // BGT gt=1
        do_fetch; do_resolve(3'd1, 2'd3, 1'b1, 1'b0, 3'd0, 1'b0);  // BGT gt=0

        // JUMP, RTE, unused class behaves as SEQ
        do_fetch; do_resolve(3'd2, 2'd0, 1'b0, 1'b0, 3'd2, 1'b1);
        do_fetch; do_resolve(3'd3, 2'd0, 1'b0, 1'b0, 3'd3, 1'b1);
        do_fetch; do_resolve(3'd6, 2'd0, 1'b1, 1'b0, 3'd0, 1'b0);

        // Overflow + div0 together with resolve_valid: overflow wins
        do_fetch; do_exc(3'b110, 1'b1, 8'hA0, 2'd2, 32'd254);

        // exc_req in IDLE: no state change, cause retained
        exc_req = 3'b001;
        step;
        exc_req = 3'd0;
        check("idle_exc_ignored", 64'({fsm_state, busy, exc_cause}),
              64'({ST_IDLE, 1'b0, 2'd2}));

        // resolve_valid in IDLE: no effect
        resolve_valid = 1'b1;
        instr_class   = 3'd2;
        step;
        resolve_valid = 1'b0;
        instr_class   = 3'd0;
        check("idle_resolve_ignored", 64'({fsm_state, busy}), 64'({ST_IDLE, 1'b0}));
        step;

        // Opcode + div0: opcode wins
        do_fetch; do_exc(3'b101, 1'b0, 8'h5C, 2'd1, 32'd253);
        // Div0 alone
        do_fetch; do_exc(3'b100, 1'b0, 8'hF7, 2'd3, 32'd255);

        // fetch_start during WAIT is ignored
        do_fetch;
        fetch_start = 1'b1;
        step;
        fetch_start = 1'b0;
        check("wait_fetch_ignored", 64'({fsm_state, busy}), 64'({ST_WAIT, 1'b1}));
        do_resolve(3'd2, 2'd0, 1'b0, 1'b0, 3'd2, 1'b1);

        // Reset in the middle of EXC_READ
        do_fetch;
        exc_req = 3'b010;
        exp_q.push_back(mk(cyc + 32'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                           2'd2, 32'd254, exp_byte));
        exp_q.push_back(mk(cyc + 32'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                           2'd2, 32'd254, exp_byte));
        step;
        exc_req = 3'd0;
        step;
        reset_n = 1'b0;
        step;
        check("midexc_reset_ctrl", 64'({pc_src, pc_write, epc_write, vec_rd, busy, done,
                                        exc_cause, fsm_state}), 64'd0);
        check("midexc_reset_vec", {vec_addr, vec_byte}, 64'd0);
        reset_n   = 1'b1;
        exp_cause = 2'd0;
        exp_addr  = 32'd0;
        exp_byte  = 32'd0;
        step;
        do_fetch; do_resolve(3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);

        repeat (5) step;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected got=%0d entries expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
